instr_prefetch_queue: RTL

INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

---
 rtl/instr_prefetch_queue.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/instr_prefetch_queue.sv
// Purpose : instruction prefetch queue; fetches sequential instructions ahead of decode
//           into a DEPTH-entry FIFO, with flush/redirect and an end-of-program halt.
// Latency : mem_req to out_valid is 2 cycles with a 1-cycle memory (push edge, then visible).
// Backpres: a request is only issued while a free slot exists, so the queue never overflows;
//           out_ready=0 simply holds the head and, once full, stops new requests.
// Ports   : clk, rst (async active-low)
//           mem_req/mem_addr      -> fetch request to instruction memory
//           mem_rvalid/mem_rdata  <- memory response
//           out_valid/out_instr/out_pc/out_ready -> head of queue to decode
//           redirect/redirect_pc  <- branch/jump flush and new fetch address
//           count, halted         -> occupancy and end-of-program status
module instr_prefetch_queue #(
   parameter int DATA_WIDTH    = 20,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DEPTH         = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       mem_req,
   output logic [ADDRESS_WIDTH-1:0]   mem_addr,
   input  logic                       mem_rvalid,
   input  logic [DATA_WIDTH-1:0]      mem_rdata,
   output logic                       out_valid,
   output logic [DATA_WIDTH-1:0]      out_instr,
   output logic [ADDRESS_WIDTH-1:0]   out_pc,
   input  logic                       out_ready,
   input  logic                       redirect,
   input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       halted
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [ADDRESS_WIDTH-1:0] LAST_PC = '1;

   typedef enum logic [1:0] {
      ST_REQ,
      ST_WAIT,
      ST_DISCARD,
      ST_HALT
   } state_t;

   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]            count_q, count_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;

   logic [DATA_WIDTH-1:0]    instr_mem_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] pc_mem_q    [DEPTH];

   logic                     queue_full;
   logic                     push;
   logic                     pop;
   logic [ADDRESS_WIDTH-1:0] pc_inc;

   assign queue_full = (count_q == CW'(DEPTH));
   assign pc_inc     = fetch_pc_q + 1'b1;

   // Request is suppressed during reset and in a redirect cycle so a stale
   // address is never sent out.
   assign mem_req  = (state_q == ST_REQ) && !queue_full && !redirect && rst;
   assign mem_addr = fetch_pc_q;

   assign push = (state_q == ST_WAIT) && mem_rvalid && !redirect;
   assign pop  = (count_q != '0) && out_ready && !redirect;

   assign out_valid = (count_q != '0);
   // Storage is not reset; gating with out_valid keeps the head outputs at 0
   // whenever the queue is empty (including during reset).
   assign out_instr = out_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign out_pc    = out_valid ? pc_mem_q[rd_ptr_q]    : '0;
   assign count     = count_q;
   assign halted    = (state_q == ST_HALT);

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = count_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         // A response still owed by memory must be swallowed before fetching
         // again. If it arrives in this very cycle it is dropped here instead.
         if ((state_q == ST_WAIT || state_q == ST_DISCARD) && !mem_rvalid) begin
            state_d = ST_DISCARD;
         end else if (redirect_pc == LAST_PC) begin
            state_d = ST_HALT;
         end else begin
            state_d = ST_REQ;
         end
      end else begin
         unique case (state_q)
            ST_REQ: begin
               if (mem_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (mem_rvalid) begin
                  fetch_pc_d = pc_inc;
                  state_d    = (pc_inc == LAST_PC) ? ST_HALT : ST_REQ;
               end
            end
            ST_DISCARD: begin
               // fetch_pc may have been redirected to the last address while
               // discarding; never fetch it.
               if (mem_rvalid) state_d = (fetch_pc_q == LAST_PC) ? ST_HALT : ST_REQ;
            end
            ST_HALT: begin
               state_d = ST_HALT;
            end
            default: state_d = ST_REQ;
         endcase

         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_REQ;
         fetch_pc_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   // Each entry records the address it was fetched from alongside the data.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[wr_ptr_q] <= mem_rdata;
         pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
      end
   end

endmodule
